// File: rtl/rob_multi_commit_pkg.sv
// Shared opcodes, widths and entry layouts for the multi-commit reorder buffer.
package rob_multi_commit_pkg;

    localparam int DATA_WID    = 32;
    localparam int ADDR_WID    = 32;
    localparam int REG_POS_WID = 5;
    localparam int OPCODE_WID  = 7;

    localparam logic [OPCODE_WID-1:0] OPCODE_S    = 7'b0100011;
    localparam logic [OPCODE_WID-1:0] OPCODE_BR   = 7'b1100011;
    localparam logic [OPCODE_WID-1:0] OPCODE_JALR = 7'b1100111;

    function automatic int rob_pos_wid(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic is_ctrl(input logic [OPCODE_WID-1:0] op);
        return (op == OPCODE_BR) || (op == OPCODE_JALR);
    endfunction

    typedef struct packed {
        logic [OPCODE_WID-1:0]  opcode;
        logic [REG_POS_WID-1:0] rd;
        logic [ADDR_WID-1:0]    pc;
        logic                   pred_jump;
    } rob_info_t;

    typedef struct packed {
        logic [DATA_WID-1:0] val;
        logic                res_jump;
        logic [ADDR_WID-1:0] res_pc;
    } rob_res_t;

endpackage

// File: rtl/rob_multi_commit_if.sv
// Issue / write-back / query / retire bundle between the core and the reorder buffer.
interface rob_multi_commit_if #(
    parameter int DEPTH    = 16,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
);
    import rob_multi_commit_pkg::*;
    localparam int POS_W = rob_pos_wid(DEPTH);

    logic                            rob_nxt_full;
    logic [POS_W:0]                  count;
    logic [POS_W-1:0]                nxt_rob_pos;
    logic                            issue;
    logic [REG_POS_WID-1:0]          issue_rd;
    logic [OPCODE_WID-1:0]           issue_opcode;
    logic [ADDR_WID-1:0]             issue_pc;
    logic                            issue_pred_jump;
    logic                            issue_is_ready;
    logic [NUM_WB-1:0]               wb_valid;
    logic [NUM_WB*POS_W-1:0]         wb_pos;
    logic [NUM_WB*DATA_WID-1:0]      wb_val;
    logic [NUM_WB-1:0]               wb_jump;
    logic [NUM_WB*ADDR_WID-1:0]      wb_pc;
    logic [POS_W-1:0]                rs1_pos;
    logic                            rs1_ready;
    logic [DATA_WID-1:0]             rs1_val;
    logic [POS_W-1:0]                rs2_pos;
    logic                            rs2_ready;
    logic [DATA_WID-1:0]             rs2_val;
    logic [COMMIT_W-1:0]             cm_valid;
    logic [COMMIT_W*POS_W-1:0]       cm_pos;
    logic [COMMIT_W-1:0]             cm_reg_write;
    logic [COMMIT_W*REG_POS_WID-1:0] cm_rd;
    logic [COMMIT_W*DATA_WID-1:0]    cm_val;
    logic                            lsb_store;
    logic [POS_W-1:0]                lsb_store_pos;
    logic                            commit_br;
    logic                            commit_br_jump;
    logic [ADDR_WID-1:0]             commit_br_pc;
    logic                            rollback;
    logic                            if_set_pc_en;
    logic [ADDR_WID-1:0]             if_set_pc;

    modport master (
        input  rob_nxt_full, count, nxt_rob_pos,
        output issue, issue_rd, issue_opcode, issue_pc, issue_pred_jump, issue_is_ready,
        output wb_valid, wb_pos, wb_val, wb_jump, wb_pc,
        output rs1_pos, rs2_pos,
        input  rs1_ready, rs1_val, rs2_ready, rs2_val,
        input  cm_valid, cm_pos, cm_reg_write, cm_rd, cm_val,
        input  lsb_store, lsb_store_pos, commit_br, commit_br_jump, commit_br_pc,
        input  rollback, if_set_pc_en, if_set_pc
    );

    modport slave (
        output rob_nxt_full, count, nxt_rob_pos,
        input  issue, issue_rd, issue_opcode, issue_pc, issue_pred_jump, issue_is_ready,
        input  wb_valid, wb_pos, wb_val, wb_jump, wb_pc,
        input  rs1_pos, rs2_pos,
        output rs1_ready, rs1_val, rs2_ready, rs2_val,
        output cm_valid, cm_pos, cm_reg_write, cm_rd, cm_val,
        output lsb_store, lsb_store_pos, commit_br, commit_br_jump, commit_br_pc,
        output rollback, if_set_pc_en, if_set_pc
    );

endinterface

// File: rtl/rob_multi_commit_select.sv
// Picks how many head entries retire this cycle: in order, ready, one store max,
// and a branch/JALR closes the group.
module rob_commit_select
    import rob_multi_commit_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int COMMIT_W = 2
) (
    input  logic [rob_pos_wid(DEPTH)-1:0] i_head,
    input  logic [rob_pos_wid(DEPTH):0]   i_count,
    input  logic [DEPTH-1:0]              i_ready,
    input  logic [OPCODE_WID-1:0]         i_opcode [DEPTH],
    output logic [1:0]                    o_n_commit,
    output logic [COMMIT_W-1:0]           o_en
);
    localparam int POS_W = rob_pos_wid(DEPTH);

    always_comb begin
        logic             go;
        logic             seen_st;
        logic [POS_W-1:0] idx;
        o_en       = '0;
        o_n_commit = '0;
        go         = 1'b1;
        seen_st    = 1'b0;
        idx        = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx = i_head + POS_W'(k);
            if (go && ((POS_W+1)'(k) < i_count) && i_ready[idx] &&
                !(seen_st && (i_opcode[idx] == OPCODE_S))) begin
                o_en[k]    = 1'b1;
                o_n_commit = o_n_commit + 2'd1;
                if (i_opcode[idx] == OPCODE_S) seen_st = 1'b1;
                if (is_ctrl(i_opcode[idx]))    go      = 1'b0;
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with NUM_WB write-back channels, COMMIT_W retirements per cycle,
// occupancy counter and same-cycle write-back bypass on the operand query ports.
module rob_multi_commit
    import rob_multi_commit_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    rob_multi_commit_if.slave bus
);
    localparam int             POS_W = rob_pos_wid(DEPTH);
    localparam logic [POS_W:0] FULL  = (POS_W+1)'(DEPTH);

    logic [POS_W-1:0] r_head, r_tail;
    logic [POS_W:0]   r_count;
    logic [DEPTH-1:0] r_ready;
    rob_info_t        r_info [DEPTH];
    rob_res_t         r_res  [DEPTH];

    logic [COMMIT_W-1:0]             r_cm_valid_p1, r_cm_reg_write_p1;
    logic [COMMIT_W*POS_W-1:0]       r_cm_pos_p1;
    logic [COMMIT_W*REG_POS_WID-1:0] r_cm_rd_p1;
    logic [COMMIT_W*DATA_WID-1:0]    r_cm_val_p1;
    logic                            r_lsb_store_p1, r_commit_br_p1, r_commit_br_jump_p1;
    logic [POS_W-1:0]                r_lsb_store_pos_p1;
    logic [ADDR_WID-1:0]             r_commit_br_pc_p1, r_if_set_pc_p1;
    logic                            r_rollback_p1, r_if_set_pc_en_p1;

    logic [OPCODE_WID-1:0] w_opcode [DEPTH];
    logic [POS_W-1:0]      w_slot_pos [COMMIT_W];
    logic [COMMIT_W-1:0]   w_cm_en;
    logic [1:0]            w_n_commit;
    logic                  w_issue_acc, w_flush;
    logic [POS_W:0]        w_nxt_count;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)    w_opcode[i]   = r_info[i].opcode;
        for (int k = 0; k < COMMIT_W; k++) w_slot_pos[k] = r_head + POS_W'(k);
    end

    rob_commit_select #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W)) u_select (
        .i_head     (r_head),
        .i_count    (r_count),
        .i_ready    (r_ready),
        .i_opcode   (w_opcode),
        .o_n_commit (w_n_commit),
        .o_en       (w_cm_en)
    );

    // A full ROB still accepts an issue when the head retires on the same edge.
    assign w_issue_acc = bus.issue && ((r_count != FULL) || (w_n_commit != 2'd0));
    assign w_flush     = rdy && r_rollback_p1;

    always_comb begin
        if (!rst_n)             w_nxt_count = '0;
        else if (!rdy)          w_nxt_count = r_count;
        else if (r_rollback_p1) w_nxt_count = '0;
        else w_nxt_count = r_count + (POS_W+1)'(w_issue_acc) - (POS_W+1)'(w_n_commit);
    end

    assign bus.rob_nxt_full = (w_nxt_count == FULL);
    assign bus.count        = r_count;
    assign bus.nxt_rob_pos  = r_tail;

    always_comb begin
        bus.rs1_ready = r_ready[bus.rs1_pos];
        bus.rs1_val   = r_res[bus.rs1_pos].val;
        bus.rs2_ready = r_ready[bus.rs2_pos];
        bus.rs2_val   = r_res[bus.rs2_pos].val;
        for (int c = NUM_WB-1; c >= 0; c--) begin
            if (bus.wb_valid[c] && (bus.wb_pos[c*POS_W +: POS_W] == bus.rs1_pos)) begin
                bus.rs1_ready = 1'b1;
                bus.rs1_val   = bus.wb_val[c*DATA_WID +: DATA_WID];
            end
            if (bus.wb_valid[c] && (bus.wb_pos[c*POS_W +: POS_W] == bus.rs2_pos)) begin
                bus.rs2_ready = 1'b1;
                bus.rs2_val   = bus.wb_val[c*DATA_WID +: DATA_WID];
            end
        end
    end

    // Pointers, ready flags and the registered retire stage; a pending rollback flushes like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            r_head              <= '0;
            r_tail              <= '0;
            r_count             <= '0;
            r_ready             <= '0;
            r_cm_valid_p1       <= '0;
            r_cm_reg_write_p1   <= '0;
            r_cm_pos_p1         <= '0;
            r_cm_rd_p1          <= '0;
            r_cm_val_p1         <= '0;
            r_lsb_store_p1      <= 1'b0;
            r_lsb_store_pos_p1  <= '0;
            r_commit_br_p1      <= 1'b0;
            r_commit_br_jump_p1 <= 1'b0;
            r_commit_br_pc_p1   <= '0;
            r_rollback_p1       <= 1'b0;
            r_if_set_pc_en_p1   <= 1'b0;
            r_if_set_pc_p1      <= '0;
        end else if (rdy) begin
            r_head  <= r_head + POS_W'(w_n_commit);
            r_tail  <= r_tail + POS_W'(w_issue_acc);
            r_count <= w_nxt_count;
            for (int c = NUM_WB-1; c >= 0; c--)
                if (bus.wb_valid[c]) r_ready[bus.wb_pos[c*POS_W +: POS_W]] <= 1'b1;
            if (w_issue_acc) r_ready[r_tail] <= bus.issue_is_ready;

            r_cm_valid_p1       <= '0;
            r_cm_reg_write_p1   <= '0;
            r_cm_pos_p1         <= '0;
            r_cm_rd_p1          <= '0;
            r_cm_val_p1         <= '0;
            r_lsb_store_p1      <= 1'b0;
            r_lsb_store_pos_p1  <= '0;
            r_commit_br_p1      <= 1'b0;
            r_commit_br_jump_p1 <= 1'b0;
            r_commit_br_pc_p1   <= '0;
            r_rollback_p1       <= 1'b0;
            r_if_set_pc_en_p1   <= 1'b0;
            r_if_set_pc_p1      <= '0;
            for (int k = 0; k < COMMIT_W; k++) begin
                if (w_cm_en[k]) begin
                    r_cm_valid_p1[k]                <= 1'b1;
                    r_cm_pos_p1[k*POS_W +: POS_W]   <= w_slot_pos[k];
                    if (r_info[w_slot_pos[k]].opcode == OPCODE_S) begin
                        r_lsb_store_p1     <= 1'b1;
                        r_lsb_store_pos_p1 <= w_slot_pos[k];
                    end else if (r_info[w_slot_pos[k]].opcode == OPCODE_BR) begin
                        r_commit_br_p1      <= 1'b1;
                        r_commit_br_jump_p1 <= r_res[w_slot_pos[k]].res_jump;
                        r_commit_br_pc_p1   <= r_info[w_slot_pos[k]].pc;
                    end else begin
                        r_cm_reg_write_p1[k]                       <= 1'b1;
                        r_cm_rd_p1[k*REG_POS_WID +: REG_POS_WID]   <= r_info[w_slot_pos[k]].rd;
                        r_cm_val_p1[k*DATA_WID +: DATA_WID]        <= r_res[w_slot_pos[k]].val;
                    end
                    if (is_ctrl(r_info[w_slot_pos[k]].opcode) &&
                        (r_info[w_slot_pos[k]].pred_jump != r_res[w_slot_pos[k]].res_jump)) begin
                        r_rollback_p1     <= 1'b1;
                        r_if_set_pc_en_p1 <= 1'b1;
                        r_if_set_pc_p1    <= r_res[w_slot_pos[k]].res_pc;
                    end
                end
            end
        end
    end

    // Entry payload carries no reset; validity is tracked solely by r_ready.
    always_ff @(posedge clk) begin
        if (rdy && !r_rollback_p1) begin
            for (int c = NUM_WB-1; c >= 0; c--) begin
                if (bus.wb_valid[c])
                    r_res[bus.wb_pos[c*POS_W +: POS_W]] <= rob_res_t'{
                        val:      bus.wb_val[c*DATA_WID +: DATA_WID],
                        res_jump: bus.wb_jump[c],
                        res_pc:   bus.wb_pc[c*ADDR_WID +: ADDR_WID]};
            end
            if (w_issue_acc) begin
                r_info[r_tail] <= rob_info_t'{opcode: bus.issue_opcode, rd: bus.issue_rd,
                                              pc: bus.issue_pc, pred_jump: bus.issue_pred_jump};
                r_res[r_tail]  <= '0;
            end
        end
    end

    assign bus.cm_valid       = r_cm_valid_p1;
    assign bus.cm_pos         = r_cm_pos_p1;
    assign bus.cm_reg_write   = r_cm_reg_write_p1;
    assign bus.cm_rd          = r_cm_rd_p1;
    assign bus.cm_val         = r_cm_val_p1;
    assign bus.lsb_store      = r_lsb_store_p1;
    assign bus.lsb_store_pos  = r_lsb_store_pos_p1;
    assign bus.commit_br      = r_commit_br_p1;
    assign bus.commit_br_jump = r_commit_br_jump_p1;
    assign bus.commit_br_pc   = r_commit_br_pc_p1;
    assign bus.rollback       = r_rollback_p1;
    assign bus.if_set_pc_en   = r_if_set_pc_en_p1;
    assign bus.if_set_pc      = r_if_set_pc_p1;

endmodule
